// File: rtl/pll_mode_sequencer.sv
// PLL mode sequencer: debounces a video-profile request, drives the
// write_from_rom / reconfig handshake of the PLL reconfig controller,
// recovers a stuck controller, waits for lock and holds the core clock
// domain in reset while the PLL is not running the selected profile.
module pll_mode_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1024,  // request stable time before a switch
    parameter int unsigned BUSY_TIMEOUT  = 1000,  // per-phase busy wait limit (>= 2)
    parameter int unsigned LOCK_TIMEOUT  = 50000, // lock wait limit after reconfig
    parameter int unsigned LOCK_STABLE   = 16,    // consecutive locked cycles for lock
    parameter int unsigned MAX_RETRIES   = 3      // aborted attempts before error (1..7)
) (
    input  logic       clk_i,
    input  logic       reset_n,
    input  logic [1:0] mode_req,
    input  logic       busy,
    input  logic       locked,
    output logic [1:0] rom_sel,
    output logic       write_from_rom,
    output logic       reconfig,
    output logic       reconfig_reset,
    output logic       core_hold,
    output logic [1:0] active_mode,
    output logic       error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETTLE    = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_LOAD_WAIT = 3'd3;
    localparam logic [2:0] S_START     = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_LOCK      = 3'd6;
    localparam logic [2:0] S_ABORT     = 3'd7;

    localparam int unsigned CW = $clog2(LOCK_STABLE + 1);

    localparam logic [15:0]   SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0]   BUSY_LOAD   = 16'(BUSY_TIMEOUT);
    localparam logic [15:0]   LOCK_LOAD   = 16'(LOCK_TIMEOUT);
    // busy is only trusted once the timer has dropped two below its load value,
    // giving the controller time to raise busy after our registered pulse.
    localparam logic [15:0]   BUSY_CHECK  = 16'(BUSY_TIMEOUT - 2);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_STABLE - 1);
    localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRIES);

    // Synchronised copies of the asynchronous inputs
    logic [1:0] mode_meta, mode_s;
    logic       locked_meta, locked_s;

    // Current state
    logic [2:0]    state;
    logic [15:0]   timer;
    logic [1:0]    target;
    logic [2:0]    retries;
    logic [CW-1:0] lock_cnt;

    // Next-state values
    logic [2:0]    state_d;
    logic [15:0]   timer_d;
    logic [1:0]    target_d;
    logic [1:0]    rom_sel_d;
    logic [1:0]    active_d;
    logic          error_d;
    logic [2:0]    retries_d;
    logic [CW-1:0] lock_cnt_d;
    logic          wfr_d;
    logic          rcfg_d;
    logic          rr_d;
    logic          hold_d;

    // Two-flop synchronisers for mode_req and locked
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            mode_meta   <= 2'd0;
            mode_s      <= 2'd0;
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old value,
            // so the two synchroniser stages stay two distinct registers.
            mode_meta   <= mode_req;
            mode_s      <= mode_meta;
            locked_meta <= locked;
            locked_s    <= locked_meta;
        end
    end

    // Sequencer next-state, timer and output decode
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state;
        timer_d    = timer;
        target_d   = target;
        rom_sel_d  = rom_sel;
        active_d   = active_mode;
        error_d    = error;
        retries_d  = retries;
        lock_cnt_d = '0;
        wfr_d      = 1'b0;
        rcfg_d     = 1'b0;
        rr_d       = 1'b0;

        case (state)
            S_IDLE: begin
                // A failed target is not retried until the request moves on.
                if (mode_s != active_mode && !(error && mode_s == target)) begin
                    target_d = mode_s;
                    error_d  = 1'b0;
                    timer_d  = SETTLE_LOAD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (mode_s != target) begin
                    target_d = mode_s;
                    timer_d  = SETTLE_LOAD;
                end else if (timer == 16'd0) begin
                    if (target == active_mode) begin
                        state_d = S_IDLE;
                    end else begin
                        rom_sel_d = target;
                        retries_d = 3'd0;
                        state_d   = S_LOAD;
                    end
                end else begin
                    timer_d = timer - 16'd1;
                end
            end
            S_LOAD: begin
                if (!busy) begin
                    wfr_d   = 1'b1;
                    timer_d = BUSY_LOAD;
                    state_d = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                if (timer <= BUSY_CHECK && !busy) begin
                    state_d = S_START;
                end else if (timer == 16'd0) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer - 16'd1;
                end
            end
            S_START: begin
                rcfg_d  = 1'b1;
                timer_d = BUSY_LOAD;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (timer <= BUSY_CHECK && !busy) begin
                    timer_d = LOCK_LOAD;
                    state_d = S_LOCK;
                end else if (timer == 16'd0) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer - 16'd1;
                end
            end
            S_LOCK: begin
                if (locked_s && lock_cnt == LOCK_LAST) begin
                    active_d  = target;
                    retries_d = 3'd0;
                    state_d   = S_IDLE;
                end else begin
                    lock_cnt_d = locked_s ? lock_cnt + 1'b1 : '0;
                    if (timer == 16'd0) begin
                        state_d = S_ABORT;
                    end else begin
                        timer_d = timer - 16'd1;
                    end
                end
            end
            S_ABORT: begin
                rr_d      = 1'b1;
                retries_d = retries + 3'd1;
                if (retries + 3'd1 == RETRY_LIMIT) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Core is released only while idle/settling on a locked PLL; after a
        // failure the old profile keeps running, so the core is let go.
        if (state_d == S_IDLE || state_d == S_SETTLE) begin
            hold_d = !error_d && !locked_s;
        end else begin
            hold_d = 1'b1;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_LOCK;
            timer          <= LOCK_LOAD;
            target         <= 2'd0;
            retries        <= 3'd0;
            lock_cnt       <= '0;
            rom_sel        <= 2'd0;
            active_mode    <= 2'd0;
            error          <= 1'b0;
            write_from_rom <= 1'b0;
            reconfig       <= 1'b0;
            reconfig_reset <= 1'b0;
            core_hold      <= 1'b1;
        end else begin
            state          <= state_d;
            timer          <= timer_d;
            target         <= target_d;
            retries        <= retries_d;
            lock_cnt       <= lock_cnt_d;
            rom_sel        <= rom_sel_d;
            active_mode    <= active_d;
            error          <= error_d;
            write_from_rom <= wfr_d;
            reconfig       <= rcfg_d;
            reconfig_reset <= rr_d;
            core_hold      <= hold_d;
        end
    end

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Self-checking bench for pll_mode_sequencer with a behavioural model of the
// reconfig controller (busy) and the PLL (locked). Short timeouts keep runs fast.
module tb_pll_mode_sequencer;

    localparam int SETTLE    = 32;
    localparam int BT        = 100;
    localparam int LT        = 400;
    localparam int LS        = 16;
    localparam int MR        = 3;
    localparam int LOAD_BUSY = 40;
    localparam int RUN_BUSY  = 40;
    localparam int RELOCK    = 60;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] mode_req;
    logic       busy;
    logic       locked;
    logic [1:0] rom_sel;
    logic       write_from_rom;
    logic       reconfig;
    logic       reconfig_reset;
    logic       core_hold;
    logic [1:0] active_mode;
    logic       error;

    always #5 clk = ~clk;

    pll_mode_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .BUSY_TIMEOUT (BT),
        .LOCK_TIMEOUT (LT),
        .LOCK_STABLE  (LS),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk_i         (clk),
        .reset_n       (reset_n),
        .mode_req      (mode_req),
        .busy          (busy),
        .locked        (locked),
        .rom_sel       (rom_sel),
        .write_from_rom(write_from_rom),
        .reconfig      (reconfig),
        .reconfig_reset(reconfig_reset),
        .core_hold     (core_hold),
        .active_mode   (active_mode),
        .error         (error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Controller / PLL model state and per-scenario observations
    int         busy_cnt = 0;
    int         relock_cnt = -1;
    bit         stuck = 1'b0;
    bit         stuck_mode = 1'b0;
    bit         lock_back = 1'b1;
    logic [1:0] cur_mode = 2'd0;
    int         tick_no = 0;
    int         c_wfr, c_rcfg, c_rr, c_multi, c_romsel_bad, c_hold_bad;
    int         t_rcfg, t_rr;

    task automatic clear_counts();
        c_wfr = 0; c_rcfg = 0; c_rr = 0; c_multi = 0;
        c_romsel_bad = 0; c_hold_bad = 0;
        t_rcfg = -1; t_rr = -1;
    endtask

    // One clock: observe outputs at the falling edge, then advance the model.
    task automatic tick();
        @(negedge clk);
        tick_no++;
        if (write_from_rom) begin
            c_wfr++;
            if (rom_sel != cur_mode) c_romsel_bad++;
            if (!core_hold) c_hold_bad++;
        end
        if (reconfig) begin
            c_rcfg++;
            if (!core_hold) c_hold_bad++;
            if (t_rcfg < 0) t_rcfg = tick_no;
        end
        if (reconfig_reset) begin
            c_rr++;
            if (t_rr < 0) t_rr = tick_no;
        end
        if (int'(write_from_rom) + int'(reconfig) + int'(reconfig_reset) > 1) c_multi++;

        if (reconfig_reset) begin
            stuck    = 1'b0;
            busy_cnt = 0;
        end else if (write_from_rom) begin
            busy_cnt = LOAD_BUSY;
        end else if (reconfig) begin
            locked = 1'b0;
            if (stuck_mode) stuck = 1'b1;
            else busy_cnt = RUN_BUSY;
            relock_cnt = lock_back ? RELOCK : -1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        if (!reconfig && relock_cnt > 0) begin
            relock_cnt--;
            if (relock_cnt == 0) begin
                locked     = 1'b1;
                relock_cnt = -1;
            end
        end
        busy = stuck || (busy_cnt > 0);
    endtask

    typedef struct {
        logic [1:0] mode;
        bit         stuck;
        bit         lock_back;
        int         cycles;
        logic [1:0] exp_active;
        bit         exp_error;
        int         exp_wfr;
        int         exp_rcfg;
        int         exp_rr;
        bit         exp_hold;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n;

        // mode, stuck busy, lock returns, cycles, active, error, wfr, rcfg, rr, core_hold
        vecs[0] = '{2'd1, 1'b0, 1'b1, 1000, 2'd1, 1'b0, 1, 1, 0, 1'b0}; // clean switch 0->1
        vecs[1] = '{2'd2, 1'b1, 1'b1, 1500, 2'd1, 1'b1, 3, 3, 3, 1'b0}; // busy stuck in RUN
        vecs[2] = '{2'd3, 1'b0, 1'b0, 2500, 2'd1, 1'b1, 3, 3, 3, 1'b0}; // lock never returns
        vecs[3] = '{2'd2, 1'b0, 1'b1, 1000, 2'd2, 1'b0, 1, 1, 0, 1'b0}; // new request clears error

        // ---- Reset values and power-up lock ----
        reset_n  = 1'b0;
        mode_req = 2'd0;
        busy     = 1'b0;
        locked   = 1'b0;
        clear_counts();
        tick();
        #1;
        check("reset rom_sel", int'(rom_sel), 0);
        check("reset active_mode", int'(active_mode), 0);
        check("reset error", int'(error), 0);
        check("reset core_hold", int'(core_hold), 1);
        check("reset pulses", int'(write_from_rom) + int'(reconfig) + int'(reconfig_reset), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        locked = 1'b1;
        // 2 synchroniser flops, then 16 locked cycles counted in LOCK.
        n = 0;
        while (core_hold && n < 100) begin
            tick();
            n++;
        end
        check("powerup core_hold fall delay", n, LS + 2);
        check("powerup active_mode", int'(active_mode), 0);
        check("powerup pulses", c_wfr + c_rcfg + c_rr, 0);

        // ---- Short glitch 0->1->0 is cancelled ----
        clear_counts();
        mode_req = 2'd1;
        repeat (10) tick();
        mode_req = 2'd0;
        repeat (200) tick();
        check("glitch pulses", c_wfr + c_rcfg + c_rr, 0);
        check("glitch active_mode", int'(active_mode), 0);
        check("glitch core_hold", int'(core_hold), 0);

        // ---- Table-driven switch scenarios ----
        for (int i = 0; i < 4; i++) begin
            clear_counts();
            cur_mode   = vecs[i].mode;
            stuck_mode = vecs[i].stuck;
            lock_back  = vecs[i].lock_back;
            mode_req   = vecs[i].mode;
            repeat (vecs[i].cycles) tick();
            check($sformatf("v%0d active_mode", i), int'(active_mode), int'(vecs[i].exp_active));
            check($sformatf("v%0d error", i), int'(error), int'(vecs[i].exp_error));
            check($sformatf("v%0d write_from_rom count", i), c_wfr, vecs[i].exp_wfr);
            check($sformatf("v%0d reconfig count", i), c_rcfg, vecs[i].exp_rcfg);
            check($sformatf("v%0d reconfig_reset count", i), c_rr, vecs[i].exp_rr);
            check($sformatf("v%0d core_hold", i), int'(core_hold), int'(vecs[i].exp_hold));
            check($sformatf("v%0d rom_sel at load", i), c_romsel_bad, 0);
            check($sformatf("v%0d core_hold low at pulse", i), c_hold_bad, 0);
            check($sformatf("v%0d overlapping pulses", i), c_multi, 0);
            // RUN waits BT+1 cycles, then ABORT registers the reset pulse.
            if (vecs[i].stuck) begin
                check($sformatf("v%0d reconfig->reconfig_reset delay", i), t_rr - t_rcfg, BT + 2);
            end
        end

        // ---- Reset asserted while in RUN ----
        clear_counts();
        cur_mode   = 2'd1;
        stuck_mode = 1'b0;
        lock_back  = 1'b1;
        mode_req   = 2'd1;
        n = 0;
        while (c_rcfg == 0 && n < 500) begin
            tick();
            n++;
        end
        check("reach RUN before reset", c_rcfg, 1);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("mid reset rom_sel", int'(rom_sel), 0);
        check("mid reset active_mode", int'(active_mode), 0);
        check("mid reset error", int'(error), 0);
        check("mid reset core_hold", int'(core_hold), 1);
        check("mid reset pulses", int'(write_from_rom) + int'(reconfig) + int'(reconfig_reset), 0);
        mode_req = 2'd0;
        repeat (3) tick();
        reset_n = 1'b1;
        clear_counts();
        repeat (200) tick();
        check("restart pulses", c_wfr + c_rcfg + c_rr, 0);
        check("restart active_mode", int'(active_mode), 0);
        check("restart error", int'(error), 0);
        check("restart core_hold", int'(core_hold), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
